// File: rtl/spc_pkg.sv
// spc_pkg: state encoding and word width shared by the serial transmitter and receiver
package spc_pkg;
    localparam int SPC_WIDTH = 16;
    typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} spc_state_e;
endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready-loaded shift register that sends a word one bit per clk with a frame_done strobe
module piso_serializer
    import spc_pkg::*;
#(
    parameter int WIDTH     = SPC_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clrs,
    input  logic [WIDTH-1:0] pdin,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sdout,
    output logic             sout_valid,
    output logic             busy,
    output logic             frame_done
);
    localparam int CW = $clog2(WIDTH);
    spc_state_e       r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_bitcnt;
    logic             r_done;
    logic             w_last;
    logic             w_accept;
    assign w_last     = (r_state == ST_SHIFT) && (r_bitcnt == '0);
    assign load_ready = (r_state == ST_IDLE) || w_last;
    assign w_accept   = load_valid && load_ready;
    assign sout_valid = (r_state == ST_SHIFT);
    assign busy       = sout_valid;
    assign frame_done = r_done;
    assign sdout      = sout_valid && (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0]);
    // A load on the last-bit edge reloads in place so consecutive frames have no gap.
    always_ff @(posedge clk) begin
        if (clrs) begin
            r_state  <= ST_IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_state  <= ST_SHIFT;
                r_shreg  <= pdin;
                r_bitcnt <= CW'(WIDTH - 1);
            end else if (r_state == ST_SHIFT) begin
                r_shreg  <= MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};
                r_state  <= w_last ? ST_IDLE : ST_SHIFT;
                r_bitcnt <= w_last ? r_bitcnt : r_bitcnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench with a behavioural LSB-shift-in receiver on the serial output
module tb_piso_serializer;
    logic        clk = 1'b0;
    logic        clrs = 1'b1;
    logic [15:0] pdin = '0;
    logic        load_valid = 1'b0;
    logic        load_ready, sdout, sout_valid, busy, frame_done;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        bitq[$];
    logic [15:0] wq[$];
    logic [15:0] rx_shreg = '0;
    bit          mon_en = 1'b0;
    int          streak = 0;
    int          max_streak = 0;
    int          n_done = 0;

    piso_serializer #(.WIDTH(16), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .clrs(clrs), .pdin(pdin), .load_valid(load_valid), .load_ready(load_ready),
        .sdout(sdout), .sout_valid(sout_valid), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Receiver model: shifts in at the LSB on every valid bit.
    always @(posedge clk) if (sout_valid) rx_shreg <= {rx_shreg[14:0], sdout};

    always @(negedge clk) begin
        if (mon_en) begin
            if (sout_valid) begin
                chk("bit_expected", 32'(bitq.size() > 0), 1);
                if (bitq.size() > 0) chk("sdout", sdout, bitq.pop_front());
                streak++;
                if (streak > max_streak) max_streak = streak;
            end else begin
                chk("idle_sdout", sdout, 0);
                streak = 0;
            end
            if (frame_done) begin
                n_done++;
                chk("done_expected", 32'(wq.size() > 0), 1);
                if (wq.size() > 0) chk("rx_word", rx_shreg, wq.pop_front());
            end
        end
    end

    task automatic send(input logic [15:0] w);
        int t = 0;
        pdin = w;
        load_valid = 1'b1;
        while (!load_ready && t < 100) begin
            tick();
            t++;
        end
        chk("accept_timeout", 32'(load_ready), 1);
        for (int i = 15; i >= 0; i--) bitq.push_back(w[i]);
        wq.push_back(w);
        tick();
        load_valid = 1'b0;
        pdin = 16'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while ((bitq.size() > 0 || wq.size() > 0 || busy) && t < 100) begin
            tick();
            t++;
        end
        tick();
        chk("drain_bits", bitq.size(), 0);
        chk("drain_words", wq.size(), 0);
    endtask

    initial begin
        int d0;
        logic [15:0] w;
        // 1: reset, with a load offered during reset that must be ignored
        tick();
        load_valid = 1'b1;
        pdin = 16'hDEAD;
        tick();
        load_valid = 1'b0;
        chk("rst_sdout", sdout, 0);
        chk("rst_valid", sout_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", load_ready, 1);
        chk("rst_done", frame_done, 0);
        clrs = 1'b0;
        mon_en = 1'b1;
        tick();
        chk("post_rst_busy", busy, 0);
        // 2: single word
        d0 = n_done;
        send(16'hA5C3);
        repeat (15) tick();
        chk("a5_ready_last", load_ready, 1);
        tick();
        chk("a5_done_pulse", frame_done, 1);
        chk("a5_idle", busy, 0);
        tick();
        chk("a5_done_clear", frame_done, 0);
        chk("a5_done_count", n_done - d0, 1);
        // 3: back-to-back
        d0 = n_done;
        max_streak = 0;
        send(16'hFFFF);
        send(16'h0001);
        drain();
        chk("b2b_streak", max_streak, 32);
        chk("b2b_done_count", n_done - d0, 2);
        // 4: load held mid-frame
        send(16'h5A5A);
        repeat (4) tick();
        chk("hold_not_ready", load_ready, 0);
        send(16'h1234);
        drain();
        // 5: abort with reset at bit 7
        d0 = n_done;
        send(16'hBEEF);
        repeat (7) tick();
        clrs = 1'b1;
        tick();
        clrs = 1'b0;
        bitq.delete();
        wq.delete();
        chk("abort_busy", busy, 0);
        chk("abort_ready", load_ready, 1);
        chk("abort_sdout", sdout, 0);
        tick();
        chk("abort_no_done", n_done - d0, 0);
        send(16'h0F0F);
        drain();
        chk("after_abort_done", n_done - d0, 1);
        // 6: random loopback
        d0 = n_done;
        for (int k = 0; k < 1000; k++) begin
            w = 16'($urandom);
            send(w);
            if ($urandom_range(3) == 0) repeat ($urandom_range(20)) tick();
        end
        drain();
        chk("rand_done_count", n_done - d0, 1000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
